// File: rtl/ls_functional_unit.sv
// Non-pipelined load/store unit between the LS reservation station and memory.
// One LDUR/STUR in flight; result returned to the ROB over a done/ready handshake.
package ls_fu_pkg;
    typedef enum logic [3:0] {
        FU_OP_NOP  = 4'd0,
        FU_OP_ADD  = 4'd1,
        FU_OP_SUB  = 4'd2,
        FU_OP_LDUR = 4'd8,
        FU_OP_STUR = 4'd9
    } fu_op_t;
endpackage

module ls_functional_unit
    import ls_fu_pkg::*;
#(
    parameter int unsigned GPR_SIZE     = 64,
    parameter int unsigned ROB_IDX_SIZE = 4,
    parameter int unsigned MEM_TIMEOUT  = 64,
    parameter int unsigned TO_W         = 7
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_rs_start,
    input  fu_op_t                  in_rs_op,
    input  logic [GPR_SIZE-1:0]     in_rs_val_a,
    input  logic [GPR_SIZE-1:0]     in_rs_val_b,
    input  logic [ROB_IDX_SIZE-1:0] in_rs_dst_rob_index,
    input  logic                    in_rob_is_mispred,
    output logic                    out_rs_ready,
    output logic                    out_mem_req_valid,
    input  logic                    in_mem_req_ready,
    output logic                    out_mem_we,
    output logic [GPR_SIZE-1:0]     out_mem_addr,
    output logic [GPR_SIZE-1:0]     out_mem_wdata,
    input  logic                    in_mem_resp_valid,
    input  logic [GPR_SIZE-1:0]     in_mem_rdata,
    output logic                    out_rob_done,
    input  logic                    in_rob_ready,
    output logic [ROB_IDX_SIZE-1:0] out_rob_dst_rob_index,
    output logic [GPR_SIZE-1:0]     out_rob_value,
    output logic                    out_rob_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RESP,
        S_RESP,
        S_DRAIN
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t                  state_q, state_d;
    logic [TO_W-1:0]         cnt_q, cnt_d;
    logic                    discard_q, discard_d;
    fu_op_t                  op_q, op_d;
    logic [GPR_SIZE-1:0]     addr_q, addr_d;
    logic [GPR_SIZE-1:0]     wdata_q, wdata_d;
    logic [ROB_IDX_SIZE-1:0] tag_q, tag_d;
    logic [GPR_SIZE-1:0]     value_q, value_d;
    logic                    fault_q, fault_d;
    logic                    rs_ready_q, rs_ready_d;
    logic                    req_valid_q, req_valid_d;
    logic                    done_q, done_d;
    logic                    we_q, we_d;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            discard_q   <= 1'b0;
            op_q        <= FU_OP_NOP;
            addr_q      <= '0;
            wdata_q     <= '0;
            tag_q       <= '0;
            value_q     <= '0;
            fault_q     <= 1'b0;
            rs_ready_q  <= 1'b1;
            req_valid_q <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            discard_q   <= discard_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            tag_q       <= tag_d;
            value_q     <= value_d;
            fault_q     <= fault_d;
            rs_ready_q  <= rs_ready_d;
            req_valid_q <= req_valid_d;
            done_q      <= done_d;
            we_q        <= we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        discard_d = discard_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tag_d     = tag_q;
        value_d   = value_q;
        fault_d   = fault_q;
        case (state_q)
            S_IDLE: begin
                if (!in_rob_is_mispred && in_rs_start && rs_ready_q) begin
                    op_d    = in_rs_op;
                    addr_d  = in_rs_val_a;
                    wdata_d = in_rs_val_b;
                    tag_d   = in_rs_dst_rob_index;
                    value_d = '0;
                    if ((in_rs_op != FU_OP_LDUR && in_rs_op != FU_OP_STUR) ||
                        in_rs_val_a[2:0] != 3'b000) begin
                        state_d = S_RESP;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        fault_d = 1'b0;
                    end
                end
            end
            S_REQ: begin
                // A request memory already took must have its response swallowed.
                if (in_mem_req_ready) begin
                    state_d   = S_WAIT_RESP;
                    cnt_d     = '0;
                    discard_d = in_rob_is_mispred;
                end else if (in_rob_is_mispred) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_RESP: begin
                if (in_mem_resp_valid) begin
                    if (discard_q || in_rob_is_mispred) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = S_RESP;
                        value_d = (op_q == FU_OP_LDUR) ? in_mem_rdata : '0;
                        fault_d = 1'b0;
                    end
                end else if (cnt_q == TO_LAST) begin
                    if (discard_q || in_rob_is_mispred) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = S_DRAIN;
                        value_d = '0;
                        fault_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (in_rob_is_mispred) begin
                        discard_d = 1'b1;
                    end
                end
            end
            S_RESP, S_DRAIN: begin
                if (in_rob_is_mispred || in_rob_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rs_ready_d  = (state_d == S_IDLE);
        req_valid_d = (state_d == S_REQ);
        done_d      = (state_d == S_RESP) || (state_d == S_DRAIN);
        we_d        = (op_d == FU_OP_STUR);
    end

    assign out_rs_ready          = rs_ready_q;
    assign out_mem_req_valid     = req_valid_q;
    assign out_mem_we            = we_q;
    assign out_mem_addr          = addr_q;
    assign out_mem_wdata         = wdata_q;
    assign out_rob_done          = done_q;
    assign out_rob_dst_rob_index = tag_q;
    assign out_rob_value         = value_q;
    assign out_rob_fault         = fault_q;

endmodule
